// File: rtl/unit_combine_display.sv
// Result combiner (XOR / OR / scan / freeze) for NUM_UNITS compute units with a
// nibble-multiplexed 7-segment driver. Optional macro LEADING_BLANK_EN blanks leading zero nibbles.
module unit_combine_display #(
    parameter int unsigned NUM_UNITS    = 2,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DWELL_CYCLES = 4,
    localparam int unsigned NIB         = DATA_W / 4,
    localparam int unsigned NIB_W       = (NIB > 1) ? $clog2(NIB) : 1,
    localparam int unsigned UNIT_W      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [NUM_UNITS*DATA_W-1:0]   unit_data,
    input  logic [NUM_UNITS-1:0]          unit_valid,
    input  logic [1:0]                    mode,
    output logic [DATA_W-1:0]             result,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [NIB_W-1:0]              nib_idx,
    output logic [UNIT_W-1:0]             unit_idx
);

    localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    localparam logic [1:0] MODE_XOR    = 2'b00;
    localparam logic [1:0] MODE_OR     = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;
    localparam logic [1:0] MODE_FREEZE = 2'b11;

    logic [DATA_W-1:0] r_cap [NUM_UNITS];
    logic [DATA_W-1:0] r_result;
    logic [CNT_W-1:0]  r_cnt;
    logic [NIB_W-1:0]  r_nib;
    logic [UNIT_W-1:0] r_unit;
    logic [1:0]        r_mode_prev;

    logic              w_tick;
    logic              w_mode_chg;
    logic              w_nib_last;
    logic              w_unit_last;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [NIB_W-1:0]  w_nib_nxt;
    logic [UNIT_W-1:0] w_unit_nxt;
    logic [DATA_W-1:0] w_xor;
    logic [DATA_W-1:0] w_or;
    logic [DATA_W-1:0] w_result_nxt;
    logic [3:0]        w_nib_val;
    logic              w_blank;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    // Dwell, nibble and scan-unit sequencing; a mode change restarts the display cycle.
    always_comb begin
        w_tick      = (r_cnt == CNT_W'(DWELL_CYCLES - 1));
        w_mode_chg  = (mode != r_mode_prev);
        w_nib_last  = (r_nib == NIB_W'(NIB - 1));
        w_unit_last = (r_unit == UNIT_W'(NUM_UNITS - 1));
        w_cnt_nxt   = w_tick ? '0 : r_cnt + CNT_W'(1);
        w_nib_nxt   = r_nib;
        w_unit_nxt  = r_unit;
        if (w_mode_chg) begin
            w_cnt_nxt = '0;
            w_nib_nxt = '0;
            if (mode == MODE_SCAN) w_unit_nxt = '0;
        end else if (w_tick) begin
            w_nib_nxt = w_nib_last ? '0 : r_nib + NIB_W'(1);
            if (mode == MODE_SCAN && w_nib_last)
                w_unit_nxt = w_unit_last ? '0 : r_unit + UNIT_W'(1);
        end
    end

    // Combine; scan follows the unit index being entered so a unit's value and its index switch together.
    always_comb begin
        w_xor = '0;
        w_or  = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_xor ^= r_cap[i];
            w_or  |= r_cap[i];
        end
        case (mode)
            MODE_XOR:  w_result_nxt = w_xor;
            MODE_OR:   w_result_nxt = w_or;
            MODE_SCAN: w_result_nxt = r_cap[w_unit_nxt];
            default:   w_result_nxt = r_result;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_UNITS; i++) r_cap[i] <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_nib       <= '0;
            r_unit      <= '0;
            r_mode_prev <= MODE_XOR;
        end else if (ena) begin
            for (int i = 0; i < NUM_UNITS; i++)
                if (unit_valid[i]) r_cap[i] <= unit_data[i*DATA_W +: DATA_W];
            r_result    <= w_result_nxt;
            r_cnt       <= w_cnt_nxt;
            r_nib       <= w_nib_nxt;
            r_unit      <= w_unit_nxt;
            r_mode_prev <= mode;
        end
    end

    // Display decode from registered state only.
    always_comb begin
        w_nib_val = 4'(r_result >> {r_nib, 2'b00});
`ifdef LEADING_BLANK_EN
        w_blank = (r_nib != '0) && ((r_result >> {r_nib, 2'b00}) == '0);
`else
        w_blank = 1'b0;
`endif
    end

    assign seg      = w_blank ? 7'h00 : hex7(w_nib_val);
    assign dp       = (r_nib == NIB_W'(NIB - 1));
    assign result   = r_result;
    assign nib_idx  = r_nib;
    assign unit_idx = r_unit;

endmodule
